// File: rtl/odd_even_stream_classifier.sv
// Streaming odd/even classifier: registers each valid sample with its class (LSB or parity),
// keeps saturating per-class counts, the current same-class streak and an alternation flag.
module odd_even_stream_classifier #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] num,
  input  logic             mode,
  input  logic             clear,
  output logic             out_valid,
  output logic [WIDTH-1:0] num_out,
  output logic             odd,
  output logic             even,
  output logic             alt,
  output logic [CNT_W-1:0] odd_cnt,
  output logic [CNT_W-1:0] even_cnt,
  output logic [CNT_W-1:0] streak,
  output logic             odd_sat,
  output logic             even_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] num_out_q, num_out_d;
  logic             odd_q, odd_d;
  logic             even_q, even_d;
  logic             alt_q, alt_d;
  logic [CNT_W-1:0] odd_cnt_q, odd_cnt_d;
  logic [CNT_W-1:0] even_cnt_q, even_cnt_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic             odd_sat_q, odd_sat_d;
  logic             even_sat_q, even_sat_d;
  logic             has_prev_q, has_prev_d;
  logic             prev_class_q, prev_class_d;

  logic             cls;
  logic [CNT_W-1:0] odd_base, even_base, streak_base;
  logic [CNT_W-1:0] odd_inc, even_inc, streak_inc;
  logic             has_prev_base, odd_sat_base, even_sat_base;

  always_comb begin
    cls = mode ? ^num : num[0];

    // Clear is folded into the "base" state so a same-cycle sample counts on top of it.
    odd_base      = clear ? '0   : odd_cnt_q;
    even_base     = clear ? '0   : even_cnt_q;
    streak_base   = clear ? '0   : streak_q;
    has_prev_base = clear ? 1'b0 : has_prev_q;
    odd_sat_base  = clear ? 1'b0 : odd_sat_q;
    even_sat_base = clear ? 1'b0 : even_sat_q;

    odd_inc    = (odd_base    == CNT_MAX) ? odd_base    : odd_base    + CNT_ONE;
    even_inc   = (even_base   == CNT_MAX) ? even_base   : even_base   + CNT_ONE;
    streak_inc = (streak_base == CNT_MAX) ? streak_base : streak_base + CNT_ONE;

    out_valid_d  = 1'b0;
    num_out_d    = num_out_q;
    odd_d        = odd_q;
    even_d       = even_q;
    alt_d        = alt_q;
    odd_cnt_d    = odd_base;
    even_cnt_d   = even_base;
    streak_d     = streak_base;
    odd_sat_d    = odd_sat_base;
    even_sat_d   = even_sat_base;
    has_prev_d   = has_prev_base;
    prev_class_d = prev_class_q;

    if (in_valid) begin
      out_valid_d  = 1'b1;
      num_out_d    = num;
      odd_d        = cls;
      even_d       = ~cls;
      alt_d        = has_prev_base & (cls != prev_class_q);
      if (cls) begin
        odd_cnt_d = odd_inc;
        odd_sat_d = odd_sat_base | (odd_inc == CNT_MAX);
      end else begin
        even_cnt_d = even_inc;
        even_sat_d = even_sat_base | (even_inc == CNT_MAX);
      end
      streak_d     = (!has_prev_base || (cls != prev_class_q)) ? CNT_ONE : streak_inc;
      has_prev_d   = 1'b1;
      prev_class_d = cls;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      num_out_q    <= '0;
      odd_q        <= 1'b0;
      even_q       <= 1'b0;
      alt_q        <= 1'b0;
      odd_cnt_q    <= '0;
      even_cnt_q   <= '0;
      streak_q     <= '0;
      odd_sat_q    <= 1'b0;
      even_sat_q   <= 1'b0;
      has_prev_q   <= 1'b0;
      prev_class_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      num_out_q    <= num_out_d;
      odd_q        <= odd_d;
      even_q       <= even_d;
      alt_q        <= alt_d;
      odd_cnt_q    <= odd_cnt_d;
      even_cnt_q   <= even_cnt_d;
      streak_q     <= streak_d;
      odd_sat_q    <= odd_sat_d;
      even_sat_q   <= even_sat_d;
      has_prev_q   <= has_prev_d;
      prev_class_q <= prev_class_d;
    end
  end

  assign out_valid = out_valid_q;
  assign num_out   = num_out_q;
  assign odd       = odd_q;
  assign even      = even_q;
  assign alt       = alt_q;
  assign odd_cnt   = odd_cnt_q;
  assign even_cnt  = even_cnt_q;
  assign streak    = streak_q;
  assign odd_sat   = odd_sat_q;
  assign even_sat  = even_sat_q;

endmodule

// File: tb/tb_odd_even_stream_classifier.sv
// Bench for odd_even_stream_classifier: two instances (CNT_W=8 and CNT_W=2) share one stimulus
// stream and are compared against an unbounded-count reference model clamped at each counter limit.
module tb_odd_even_stream_classifier;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, mode, clear;
  logic [3:0] num;

  logic       a_out_valid, a_odd, a_even, a_alt, a_odd_sat, a_even_sat;
  logic [3:0] a_num_out;
  logic [7:0] a_odd_cnt, a_even_cnt, a_streak;

  logic       b_out_valid, b_odd, b_even, b_alt, b_odd_sat, b_even_sat;
  logic [3:0] b_num_out;
  logic [1:0] b_odd_cnt, b_even_cnt, b_streak;

  int tests_run = 0;
  int failed    = 0;

  // reference model: totals since last clear/reset, uncapped
  bit       m_ov, m_odd, m_even, m_alt, m_has_prev, m_prev;
  bit [3:0] m_num;
  int       m_odd_tot, m_even_tot, m_run;

  always #5 clk = ~clk;

  odd_even_stream_classifier #(.WIDTH(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num(num), .mode(mode), .clear(clear),
    .out_valid(a_out_valid), .num_out(a_num_out), .odd(a_odd), .even(a_even), .alt(a_alt),
    .odd_cnt(a_odd_cnt), .even_cnt(a_even_cnt), .streak(a_streak),
    .odd_sat(a_odd_sat), .even_sat(a_even_sat)
  );

  odd_even_stream_classifier #(.WIDTH(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num(num), .mode(mode), .clear(clear),
    .out_valid(b_out_valid), .num_out(b_num_out), .odd(b_odd), .even(b_even), .alt(b_alt),
    .odd_cnt(b_odd_cnt), .even_cnt(b_even_cnt), .streak(b_streak),
    .odd_sat(b_odd_sat), .even_sat(b_even_sat)
  );

  function automatic int clampi(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  function automatic logic [33:0] obs_a();
    return {a_out_valid, a_num_out, a_odd, a_even, a_alt,
            a_odd_cnt, a_even_cnt, a_streak, a_odd_sat, a_even_sat};
  endfunction

  function automatic logic [33:0] exp_a();
    return {m_ov, m_num, m_odd, m_even, m_alt,
            8'(clampi(m_odd_tot, 255)), 8'(clampi(m_even_tot, 255)), 8'(clampi(m_run, 255)),
            (m_odd_tot >= 255), (m_even_tot >= 255)};
  endfunction

  function automatic logic [15:0] obs_b();
    return {b_out_valid, b_num_out, b_odd, b_even, b_alt,
            b_odd_cnt, b_even_cnt, b_streak, b_odd_sat, b_even_sat};
  endfunction

  function automatic logic [15:0] exp_b();
    return {m_ov, m_num, m_odd, m_even, m_alt,
            2'(clampi(m_odd_tot, 3)), 2'(clampi(m_even_tot, 3)), 2'(clampi(m_run, 3)),
            (m_odd_tot >= 3), (m_even_tot >= 3)};
  endfunction

  // Drive one cycle of stimulus and advance the model past the edge; sample point is edge+1.
  task automatic cycle(input bit r, input bit v, input bit [3:0] n, input bit md, input bit clr);
    bit c;
    rst_n = r; in_valid = v; num = n; mode = md; clear = clr;
    @(posedge clk);
    if (!r) begin
      m_ov = 0; m_num = 0; m_odd = 0; m_even = 0; m_alt = 0;
      m_odd_tot = 0; m_even_tot = 0; m_run = 0; m_has_prev = 0; m_prev = 0;
    end else begin
      m_ov = v;
      if (clr) begin
        m_odd_tot = 0; m_even_tot = 0; m_run = 0; m_has_prev = 0;
      end
      if (v) begin
        c = md ? ($countones(n) % 2 == 1) : (n % 2 == 1);
        m_alt = m_has_prev && (c != m_prev);
        m_run = (m_has_prev && c == m_prev) ? m_run + 1 : 1;
        if (c) m_odd_tot++; else m_even_tot++;
        m_has_prev = 1; m_prev = c;
        m_num = n; m_odd = c; m_even = !c;
      end
    end
    #1;
  endtask

  function automatic bit [3:0] odd_sample(input bit md);
    bit [3:0] n;
    n = 4'($urandom);
    if (md) n[0] = ~(^n[3:1]);
    else    n[0] = 1'b1;
    return n;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      tests_run++;
      if (obs_a() !== '0) begin failed++; $display("FAIL reset_a: got %h expected 0", obs_a()); end
      tests_run++;
      if (obs_b() !== '0) begin failed++; $display("FAIL reset_b: got %h expected 0", obs_b()); end
    end
  endtask

  task automatic test_lsb_sequence();
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 4'(i), 0, 0);
      tests_run++;
      if (obs_a() !== exp_a()) begin failed++; $display("FAIL lsb_seq_a[%0d]: got %h expected %h", i, obs_a(), exp_a()); end
      tests_run++;
      if (obs_b() !== exp_b()) begin failed++; $display("FAIL lsb_seq_b[%0d]: got %h expected %h", i, obs_b(), exp_b()); end
      tests_run++;
      if ({a_odd, a_even, a_alt, a_streak} !== {(i % 2 == 1), (i % 2 == 0), (i != 0), 8'd1}) begin
        failed++; $display("FAIL lsb_seq_cls[%0d]: got odd=%b even=%b alt=%b streak=%0d", i, a_odd, a_even, a_alt, a_streak);
      end
    end
    tests_run++;
    if ({a_odd_cnt, a_even_cnt} !== {8'd5, 8'd5}) begin
      failed++; $display("FAIL lsb_seq_final: got odd_cnt=%0d even_cnt=%0d expected 5 5", a_odd_cnt, a_even_cnt);
    end
  endtask

  task automatic test_parity();
    bit [3:0] seq [3] = '{4'b0011, 4'b0101, 4'b0111};
    cycle(1, 0, 4'($urandom), 1'($urandom), 1);
    tests_run++;
    if (obs_a() !== exp_a()) begin failed++; $display("FAIL parity_clear_a: got %h expected %h", obs_a(), exp_a()); end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, seq[i], 1, 0);
      tests_run++;
      if (obs_a() !== exp_a()) begin failed++; $display("FAIL parity_a[%0d]: got %h expected %h", i, obs_a(), exp_a()); end
      tests_run++;
      if (obs_b() !== exp_b()) begin failed++; $display("FAIL parity_b[%0d]: got %h expected %h", i, obs_b(), exp_b()); end
      if (i == 1) begin
        tests_run++;
        if (a_streak !== 8'd2) begin failed++; $display("FAIL parity_streak2: got %0d expected 2", a_streak); end
      end
    end
    tests_run++;
    if ({a_odd, a_streak, a_alt, a_odd_cnt, a_even_cnt} !== {1'b1, 8'd1, 1'b1, 8'd1, 8'd2}) begin
      failed++; $display("FAIL parity_final: got odd=%b streak=%0d alt=%b odd_cnt=%0d even_cnt=%0d",
                         a_odd, a_streak, a_alt, a_odd_cnt, a_even_cnt);
    end
  endtask

  task automatic test_saturation();
    bit [1:0] want [7] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    bit md;
    cycle(1, 0, 4'($urandom), 0, 1);
    for (int i = 0; i < 7; i++) begin
      md = 1'($urandom);
      cycle(1, 1, odd_sample(md), md, 0);
      tests_run++;
      if ({b_odd_cnt, b_odd_sat, b_streak, b_even_cnt} !== {want[i], (i >= 2), want[i], 2'd0}) begin
        failed++; $display("FAIL sat_b[%0d]: got odd_cnt=%0d odd_sat=%b streak=%0d even_cnt=%0d expected %0d %b %0d 0",
                           i, b_odd_cnt, b_odd_sat, b_streak, b_even_cnt, want[i], (i >= 2), want[i]);
      end
      tests_run++;
      if (obs_b() !== exp_b()) begin failed++; $display("FAIL sat_model_b[%0d]: got %h expected %h", i, obs_b(), exp_b()); end
      tests_run++;
      if (obs_a() !== exp_a()) begin failed++; $display("FAIL sat_model_a[%0d]: got %h expected %h", i, obs_a(), exp_a()); end
    end
  endtask

  task automatic test_clear_with_sample();
    for (int i = 0; i < 6; i++) cycle(1, 1, 4'($urandom), 1'($urandom), 0);
    cycle(1, 1, 4'b0110, 0, 1);
    tests_run++;
    if ({a_odd_cnt, a_even_cnt, a_streak, a_alt, a_odd_sat, a_even_sat, a_out_valid} !==
        {8'd0, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failed++; $display("FAIL clear_sample_a: got odd_cnt=%0d even_cnt=%0d streak=%0d alt=%b sat=%b%b ov=%b",
                         a_odd_cnt, a_even_cnt, a_streak, a_alt, a_odd_sat, a_even_sat, a_out_valid);
    end
    tests_run++;
    if (obs_b() !== exp_b()) begin failed++; $display("FAIL clear_sample_b: got %h expected %h", obs_b(), exp_b()); end
  endtask

  task automatic test_midstream_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1, 4'($urandom), 1'($urandom), 0);
    cycle(0, 1, 4'($urandom), 1'($urandom), 0);
    tests_run++;
    if (obs_a() !== '0) begin failed++; $display("FAIL midreset_a: got %h expected 0", obs_a()); end
    tests_run++;
    if (obs_b() !== '0) begin failed++; $display("FAIL midreset_b: got %h expected 0", obs_b()); end
    cycle(1, 1, 4'($urandom), 1'($urandom), 0);
    tests_run++;
    if ({a_out_valid, a_alt, a_streak} !== {1'b1, 1'b0, 8'd1}) begin
      failed++; $display("FAIL midreset_first: got ov=%b alt=%b streak=%0d expected 1 0 1", a_out_valid, a_alt, a_streak);
    end
    tests_run++;
    if (obs_a() !== exp_a()) begin failed++; $display("FAIL midreset_model_a: got %h expected %h", obs_a(), exp_a()); end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 400; i++) begin
      cycle(1, ($urandom_range(0, 2) != 0), 4'($urandom), 1'($urandom), ($urandom_range(0, 40) == 0));
      tests_run++;
      if (obs_a() !== exp_a()) begin failed++; $display("FAIL gaps_a[%0d]: got %h expected %h", i, obs_a(), exp_a()); end
      tests_run++;
      if (obs_b() !== exp_b()) begin failed++; $display("FAIL gaps_b[%0d]: got %h expected %h", i, obs_b(), exp_b()); end
    end
  endtask

  task automatic test_back_to_back();
    bit md;
    for (int i = 0; i < 300; i++) begin
      md = 1'($urandom);
      // bias toward odd so the 8-bit odd counter reaches its limit
      cycle(1, 1, ($urandom_range(0, 9) != 0) ? odd_sample(md) : 4'($urandom), md, 0);
      tests_run++;
      if (obs_a() !== exp_a()) begin failed++; $display("FAIL b2b_a[%0d]: got %h expected %h", i, obs_a(), exp_a()); end
      tests_run++;
      if (obs_b() !== exp_b()) begin failed++; $display("FAIL b2b_b[%0d]: got %h expected %h", i, obs_b(), exp_b()); end
    end
  endtask

  initial begin
    rst_n = 0; in_valid = 0; num = '0; mode = 0; clear = 0;
    test_reset();
    test_lsb_sequence();
    test_parity();
    test_saturation();
    test_clear_with_sample();
    test_midstream_reset();
    test_gaps();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
